serial_adder_ctrl: RTL and testbench

- Bit-serial multi-bit adder controller.
- Time-multiplexes one full_adder instance (ports a, b, cin, sum, cout) across WIDTH bit positions, LSB first, with a registered carry between cycles.
- Accepts operand pairs over a valid/ready input handshake and returns the result over a valid/ready output handshake.
- Sits between an operand source and a result sink wherever area matters more than latency.

---
 rtl/serial_adder_ctrl.sv | 172 +++++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_ctrl (with helper full_adder)
// Description : Bit-serial WIDTH-bit adder. One full-adder cell is reused
//               across all bit positions, LSB first, with the carry held in
//               a register between cycles. Operands arrive over a valid/ready
//               handshake and the result leaves over another one.
// Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Single-bit full adder cell, shared by every bit position of the operands.
// ----------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// ----------------------------------------------------------------------------
// Controller: IDLE accepts an operand pair, RUN steps one bit per cycle for
// WIDTH cycles, DONE presents the result until the sink takes it.
// Legal WIDTH range is 1..32.
// ----------------------------------------------------------------------------
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Counter is wide enough to hold WIDTH itself (it steps one past the
    // last bit index on the final RUN cycle).
    localparam int               c_CW   = $clog2(WIDTH) + 1;
    localparam logic [c_CW-1:0]  c_LAST = c_CW'(WIDTH - 1);
    localparam logic [c_CW-1:0]  c_ONE  = c_CW'(1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic             r_carry;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic [c_CW-1:0]  r_cnt;

    logic             w_accept;
    logic             w_release;
    logic             w_run;
    logic             w_last;
    logic             w_fa_sum;
    logic             w_fa_cout;
    logic [WIDTH-1:0] w_sum_next;

    // Handshake strobes and run-phase decode, all derived from the state
    // register so that ready/valid never combinationally depend on inputs
    // other than the matching valid/ready.
    assign w_accept  = in_valid  & (r_state == c_IDLE);
    assign w_release = out_ready & (r_state == c_DONE);
    assign w_run     = (r_state == c_RUN);
    assign w_last    = (r_cnt == c_LAST);

    // Ready/valid come straight from the state, so an asynchronous reset
    // drops out_valid immediately and no partial result is ever shown.
    assign in_ready  = (r_state == c_IDLE);
    assign out_valid = (r_state == c_DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;

    full_adder u_fa (
        .a    (r_sa[0]),
        .b    (r_sb[0]),
        .cin  (r_carry),
        .sum  (w_fa_sum),
        .cout (w_fa_cout)
    );

    // New sum bit enters at the MSB while the accumulated bits move toward
    // the LSB; written this way it also holds for WIDTH == 1.
    always_comb begin
        w_sum_next            = r_sum >> 1;
        w_sum_next[WIDTH-1]   = w_fa_sum;
    end

    // Control FSM: IDLE -> RUN on acceptance, RUN -> DONE after the final
    // bit, DONE -> IDLE once the sink accepts the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            case (r_state)
                c_IDLE:  if (w_accept)  r_state <= c_RUN;
                c_RUN:   if (w_last)    r_state <= c_DONE;
                c_DONE:  if (w_release) r_state <= c_IDLE;
                default:                r_state <= c_IDLE;
            endcase
        end
    end

    // Bit counter: cleared at acceptance, advanced every RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if (w_run) begin
            r_cnt <= r_cnt + c_ONE;
        end
    end

    // Operand shift registers and running carry: loaded at acceptance,
    // consumed one bit per RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sa    <= '0;
            r_sb    <= '0;
            r_carry <= 1'b0;
        end else if (w_accept) begin
            r_sa    <= a;
            r_sb    <= b;
            r_carry <= cin;
        end else if (w_run) begin
            r_sa    <= r_sa >> 1;
            r_sb    <= r_sb >> 1;
            r_carry <= w_fa_cout;
        end
    end

    // Result sum register: cleared at acceptance, built up during RUN, and
    // otherwise held (stable through DONE and IDLE).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum <= '0;
        end else if (w_accept) begin
            r_sum <= '0;
        end else if (w_run) begin
            r_sum <= w_sum_next;
        end
    end

    // Carry-out register: takes the carry of the MSB on the final bit step
    // and holds it until the next operation completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cout <= 1'b0;
        end else if (w_run && w_last) begin
            r_cout <= w_fa_cout;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder_ctrl
// Description : Self-checking bench for serial_adder_ctrl. An 8-bit instance
//               covers reset, directed carries, backpressure, ignored inputs,
//               random traffic and reset mid-run; a 4-bit instance is driven
//               through every a/b/cin combination back to back.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // 8-bit instance signals
    logic       d8_in_valid, d8_in_ready, d8_cin, d8_out_valid, d8_out_ready, d8_cout;
    logic [7:0] d8_a, d8_b, d8_sum;

    // 4-bit instance signals
    logic       d4_in_valid, d4_in_ready, d4_cin, d4_out_valid, d4_out_ready, d4_cout;
    logic [3:0] d4_a, d4_b, d4_sum;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int n4_seen = 0;

    logic [4:0] q4[$];

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (d8_in_valid),
        .in_ready  (d8_in_ready),
        .a         (d8_a),
        .b         (d8_b),
        .cin       (d8_cin),
        .out_valid (d8_out_valid),
        .out_ready (d8_out_ready),
        .sum       (d8_sum),
        .cout      (d8_cout)
    );

    serial_adder_ctrl #(.WIDTH(4)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (d4_in_valid),
        .in_ready  (d4_in_ready),
        .a         (d4_a),
        .b         (d4_b),
        .cin       (d4_cin),
        .out_valid (d4_out_valid),
        .out_ready (d4_out_ready),
        .sum       (d4_sum),
        .cout      (d4_cout)
    );

    // Free-running edge counter used to measure acceptance spacing.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One 8-bit transaction. Called at a negedge with the DUT idle.
    // The reference result is plain integer addition of the captured operands.
    task automatic xact8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                         input int hold, input bit noise);
        logic [8:0] exp;
        int k;
        exp = 9'(ta) + 9'(tb) + 9'(tc);
        chk("in_ready_idle", d8_in_ready, 1);
        d8_a = ta; d8_b = tb; d8_cin = tc; d8_in_valid = 1'b1;
        @(posedge clk);                       // acceptance edge T
        @(negedge clk);
        d8_in_valid = 1'b0;
        chk("in_ready_busy", d8_in_ready, 0);
        chk("out_valid_busy", d8_out_valid, 0);
        k = 0;
        while (!d8_out_valid && k < 40) begin
            if (noise) begin
                d8_in_valid  = 1'($urandom);
                d8_a         = 8'($urandom);
                d8_b         = 8'($urandom);
                d8_cin       = 1'($urandom);
                d8_out_ready = 1'($urandom);
            end
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        d8_in_valid  = 1'b0;
        d8_out_ready = 1'b0;
        // out_valid registered by edge T+8, hence seen at edge T+9
        chk("latency", 64'(k), 64'd8);
        chk("result", {d8_cout, d8_sum}, exp);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", d8_out_valid, 1);
            chk("hold_ready", d8_in_ready, 0);
            chk("hold_result", {d8_cout, d8_sum}, exp);
        end
        d8_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        d8_out_ready = 1'b0;
        chk("released_valid", d8_out_valid, 0);
        chk("released_ready", d8_in_ready, 1);
        chk("idle_keeps_result", {d8_cout, d8_sum}, exp);
    endtask

    // Collects 4-bit results whenever a result handshake is about to occur.
    always @(negedge clk) begin
        if (d4_out_valid && d4_out_ready) begin
            n4_seen <= n4_seen + 1;
            if (q4.size() == 0) chk("d4_unexpected", 1, 0);
            else                chk("d4_result", {d4_cout, d4_sum}, q4.pop_front());
        end
    end

    // Watchdog: the run must never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int last_acc;
        int w;
        rst = 1'b1;
        d8_in_valid = 0; d8_a = 0; d8_b = 0; d8_cin = 0; d8_out_ready = 0;
        d4_in_valid = 0; d4_a = 0; d4_b = 0; d4_cin = 0; d4_out_ready = 1;

        // Reset for three cycles, then check reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", d8_in_ready, 1);
        chk("rst_out_valid", d8_out_valid, 0);
        chk("rst_sum", d8_sum, 0);
        chk("rst_cout", d8_cout, 0);
        chk("rst4_in_ready", d4_in_ready, 1);
        chk("rst4_result", {d4_cout, d4_sum}, 0);

        // Directed cases: carry ripple, carry-in path, plain add, with
        // backpressure and input noise while running.
        xact8(8'hFF, 8'h01, 1'b0, 0, 0);
        xact8(8'hA5, 8'h5A, 1'b1, 5, 1);
        xact8(8'h12, 8'h34, 1'b0, 5, 1);
        xact8(8'h00, 8'h00, 1'b0, 1, 0);
        xact8(8'hFF, 8'hFF, 1'b1, 0, 1);

        // Random traffic.
        for (int i = 0; i < 25; i++)
            xact8(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));

        // Reset three cycles into a run: aborts immediately.
        d8_a = 8'hFF; d8_b = 8'hFF; d8_cin = 1'b0; d8_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        d8_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", d8_out_valid, 0);
        chk("midrst_in_ready", d8_in_ready, 1);
        chk("midrst_result", {d8_cout, d8_sum}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        xact8(8'h01, 8'h01, 1'b0, 0, 0);

        // Exhaustive 4-bit sweep, in_valid held high, out_ready always 1.
        last_acc = 0;
        for (int i = 0; i < 512; i++) begin
            d4_a = i[3:0]; d4_b = i[7:4]; d4_cin = i[8]; d4_in_valid = 1'b1;
            w = 0;
            while (!d4_in_ready && w < 20) begin
                @(negedge clk);
                w++;
            end
            if (!d4_in_ready) begin
                chk("d4_accept_timeout", 0, 1);
                break;
            end
            q4.push_back(5'(i[3:0]) + 5'(i[7:4]) + 5'(i[8]));
            @(posedge clk);
            @(negedge clk);
            if (i > 0) chk("d4_spacing", 64'(cyc - last_acc), 64'd6);
            last_acc = cyc;
        end
        d4_in_valid = 1'b0;
        w = 0;
        while (q4.size() != 0 && w < 40) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        chk("d4_count", 64'(n4_seen), 64'd512);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
